md_sched: RTL and testbench



---
 rtl/md_sched_pkg.sv | 30 +++
 rtl/md_fifo.sv | 50 +++++
 rtl/md_sched.sv | 103 ++++++++++
 tb/tb_md_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared md-op encoding, queue entry layout and HI/LO unit latencies for the
// multiply/divide issue scheduler.
package md_sched_pkg;

    // bit0: mult/div; bit2 with bit0: divide; 3'b100 is unused.
    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MTHI  = 3'b010,
        MD_MULTU = 3'b011,
        MD_DIV   = 3'b101,
        MD_MTLO  = 3'b110,
        MD_DIVU  = 3'b111
    } md_op_e;

    localparam int MD_MULT_LAT = 6;
    localparam int MD_DIV_LAT  = 11;
    localparam int MD_ENTRY_W  = 67;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_entry_t;

    function automatic logic op_is_md(input logic [2:0] op);
        return op[0] | op[1];
    endfunction

endpackage

// File: rtl/md_fifo.sv
// Generic synchronous circular FIFO; push while full is legal only when a pop
// happens in the same cycle (the slot under the head is reused).
module md_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int W     = 67
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [W-1:0]     i_data,
    output logic [W-1:0]     o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count
);

    logic [W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/md_sched.sv
// In-order issue scheduler for the HI/LO mult/div unit with MFHI/MFLO hazard stall.
// Optional same-cycle bypass of an empty queue: define MD_SCHED_BYPASS_EN.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             req_accept,
    input  logic             rd_req,
    output logic             stall,
    output logic [2:0]       md_start,
    output logic [31:0]      md_srcA,
    output logic [31:0]      md_srcB,
    input  logic             md_busy,
    output logic [PTR_W:0]   q_count
);

    md_entry_t  w_req;
    md_entry_t  w_head;
    md_entry_t  w_sel;
    logic       w_is_md;
    logic       w_full;
    logic       w_empty;
    logic       w_issue;
    logic       w_accept;
    logic       w_bypass;
    logic       w_fire;
    logic       w_push;

    logic       r_issued;
    logic [2:0] r_start;
    logic [31:0] r_srcA;
    logic [31:0] r_srcB;

    assign w_req = '{op: req_op, a: req_a, b: req_b};

    md_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (MD_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_issue),
        .i_data  (w_req),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (q_count)
    );

    assign w_is_md = op_is_md(req_op);

    // r_issued forces one dead cycle after every start so the unit's busy flag
    // is visible before the next decision; this also keeps MTHI/MTLO behind a
    // running MULT/DIV.
    assign w_issue  = ~w_empty & ~md_busy & ~r_issued;
    assign w_accept = req_valid & w_is_md & (~w_full | w_issue);

`ifdef MD_SCHED_BYPASS_EN
    assign w_bypass = w_accept & w_empty & ~md_busy & ~r_issued;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fire = w_issue | w_bypass;
    assign w_push = w_accept & ~w_bypass;
    assign w_sel  = w_bypass ? w_req : w_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issued <= 1'b0;
            r_start  <= MD_NONE;
            r_srcA   <= '0;
            r_srcB   <= '0;
        end else begin
            r_issued <= w_fire;
            r_start  <= w_fire ? w_sel.op : MD_NONE;
            if (w_fire) begin
                r_srcA <= w_sel.a;
                r_srcB <= w_sel.b;
            end
        end
    end

    // A HI/LO read waits until nothing older is queued, starting or executing.
    assign stall = (rd_req & (~w_empty | md_busy | (r_start != MD_NONE) | r_issued))
                 | (req_valid & w_is_md & ~w_accept);

    assign req_accept = w_accept;
    assign md_start   = r_start;
    assign md_srcA    = r_srcA;
    assign md_srcB    = r_srcB;

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched with a behavioural HI/LO unit driving md_busy.
module tb_md_sched;
    import md_sched_pkg::*;

`ifdef MD_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_accept;
    logic        rd_req = 1'b0;
    logic        stall;
    logic [2:0]  md_start;
    logic [31:0] md_srcA;
    logic [31:0] md_srcB;
    logic        md_busy;
    logic [2:0]  q_count;

    md_sched #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_accept(req_accept), .rd_req(rd_req),
        .stall(stall), .md_start(md_start), .md_srcA(md_srcA), .md_srcB(md_srcB),
        .md_busy(md_busy), .q_count(q_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural HI/LO unit: busy rises the cycle after start.
    int unsigned u_cnt = 0;
    logic [31:0] u_hi = '0;
    logic [31:0] u_lo = '0;
    assign md_busy = (u_cnt != 0);

    always @(posedge clk) begin
        case (md_start)
            MD_MULT: begin
                {u_hi, u_lo} <= {{32{md_srcA[31]}}, md_srcA} * {{32{md_srcB[31]}}, md_srcB};
                u_cnt <= MD_MULT_LAT;
            end
            MD_MULTU: begin
                {u_hi, u_lo} <= {32'b0, md_srcA} * {32'b0, md_srcB};
                u_cnt <= MD_MULT_LAT;
            end
            MD_DIV: begin
                u_lo  <= $signed(md_srcA) / $signed(md_srcB);
                u_hi  <= $signed(md_srcA) % $signed(md_srcB);
                u_cnt <= MD_DIV_LAT;
            end
            MD_DIVU: begin
                u_lo  <= md_srcA / md_srcB;
                u_hi  <= md_srcA % md_srcB;
                u_cnt <= MD_DIV_LAT;
            end
            MD_MTHI: u_hi <= md_srcA;
            MD_MTLO: u_lo <= md_srcA;
            default: if (u_cnt != 0) u_cnt <= u_cnt - 1;
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] srcA_log[$];
    int          last_div = 0;
    int          last_mthi = 0;

    // Monitor: every start pulse must match the oldest expected request.
    always @(negedge clk) begin
        if (!reset && md_start != MD_NONE) begin
            chk("start_while_busy", {31'b0, md_busy}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_start", {29'b0, md_start}, {29'b0, MD_NONE});
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("start_op", {29'b0, md_start}, {29'b0, e.op});
                chk("start_srcA", md_srcA, e.a);
                chk("start_srcB", md_srcB, e.b);
            end
            srcA_log.push_back(md_srcA);
            if (md_start == MD_DIV)  last_div  = cyc;
            if (md_start == MD_MTHI) last_mthi = cyc;
        end
    end

    // All tasks start and return at posedge+1.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        exp_t e;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        k = 0;
        @(negedge clk);
        while (!req_accept && k < 200) begin
            @(posedge clk); #1;
            @(negedge clk);
            k++;
        end
        if (!req_accept) chk("send_timeout", 32'd0, 32'd1);
        else begin
            e.op = op; e.a = a; e.b = b;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (!(q_count == 0 && !md_busy && md_start == MD_NONE) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_q_count", {29'b0, q_count}, 32'd0);
        chk("rst_md_start", {29'b0, md_start}, {29'b0, MD_NONE});
        chk("rst_srcA", md_srcA, 32'd0);
        chk("rst_srcB", md_srcB, 32'd0);
        chk("rst_accept", {31'b0, req_accept}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;

        // Non-MD op is ignored
        req_valid = 1'b1; req_op = 3'b100; req_a = 32'h1;
        @(negedge clk);
        chk("nonmd_accept", {31'b0, req_accept}, 32'd0);
        chk("nonmd_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("nonmd_q_count", {29'b0, q_count}, 32'd0);
        @(posedge clk); #1;

        // Reset mid-queue
        send(MD_DIV, 32'd9, 32'd3);
        send(MD_MULT, 32'hA1, 32'd1);
        send(MD_MULT, 32'hA2, 32'd1);
        send(MD_MULT, 32'hA3, 32'd1);
        @(negedge clk);
        chk("midq_q_count", {29'b0, q_count}, 32'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midq_rst_q_count", {29'b0, q_count}, 32'd0);
        chk("midq_rst_md_start", {29'b0, md_start}, {29'b0, MD_NONE});
        chk("midq_rst_stall", {31'b0, stall}, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        wait_idle();

        // MULT then MFLO: stall until unit completes
        send(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        rd_req = 1'b1;
        n = 0;
        @(negedge clk);
        chk("mflo_stall_first", {31'b0, stall}, 32'd1);
        while (stall && n < 50) begin
            n++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        chk("mflo_stall_cycles", n, BYP ? 32'd7 : 32'd8);
        chk("mflo_busy_at_release", {31'b0, md_busy}, 32'd0);
        chk("mflo_lo", u_lo, 32'hFFFF_FFFE);
        chk("mflo_hi", u_hi, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rd_req = 1'b0;
        wait_idle();

        // DIV then MTHI back-to-back: MTHI waits for DIV busy to end
        send(MD_DIV, 32'd7, 32'd2);
        send(MD_MTHI, 32'h55, 32'd0);
        wait_idle();
        chk("mthi_after_div", last_mthi - last_div, 32'd13);
        chk("div_mthi_hi", u_hi, 32'h55);
        chk("div_mthi_lo", u_lo, 32'd3);

        // Fill queue behind a busy DIV; fifth request waits for first issue
        send(MD_DIV, 32'd100, 32'd7);
        for (int i = 0; i < 4; i++) send(MD_MULT, 32'h10 + i, 32'd3);
        req_valid = 1'b1; req_op = MD_MULT; req_a = 32'h14; req_b = 32'd3;
        @(negedge clk);
        chk("full_accept", {31'b0, req_accept}, 32'd0);
        chk("full_stall", {31'b0, stall}, 32'd1);
        chk("full_q_count", {29'b0, q_count}, 32'd4);
        n = 0;
        while (!req_accept && n < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("full_eventual_accept", {31'b0, req_accept}, 32'd1);
        chk("full_accept_q_count", {29'b0, q_count}, 32'd4);
        chk("full_accept_stall", {31'b0, stall}, 32'd0);
        e.op = MD_MULT; e.a = 32'h14; e.b = 32'd3;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("full_issue_start", {29'b0, md_start}, {29'b0, MD_MULT});
        chk("full_issue_srcA", md_srcA, 32'h10);
        chk("full_after_q_count", {29'b0, q_count}, 32'd4);
        @(posedge clk); #1;
        wait_idle();

        // Pointer wrap: issue order follows request order
        srcA_log.delete();
        for (int i = 1; i <= 6; i++) send(MD_MULTU, i, 32'd2);
        wait_idle();
        chk("wrap_count", srcA_log.size(), 32'd6);
        for (int i = 0; i < 6 && i < srcA_log.size(); i++)
            chk($sformatf("wrap_order_%0d", i), srcA_log[i], i + 1);

        // Request-to-start latency from idle
        req_valid = 1'b1; req_op = MD_MULTU; req_a = 32'h77; req_b = 32'd1;
        @(negedge clk);
        chk("lat_accept", {31'b0, req_accept}, 32'd1);
        chk("lat_q_count0", {29'b0, q_count}, 32'd0);
        e.op = MD_MULTU; e.a = 32'h77; e.b = 32'd1;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("lat_start_t1", {29'b0, md_start}, BYP ? {29'b0, MD_MULTU} : {29'b0, MD_NONE});
        chk("lat_q_count1", {29'b0, q_count}, BYP ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_start_t2", {29'b0, md_start}, BYP ? {29'b0, MD_NONE} : {29'b0, MD_MULTU});
        @(posedge clk); #1;
        wait_idle();

        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
